// File: rtl/disk_stub_framer.sv
// -----------------------------------------------------------------------------
// disk_stub_framer
//   Collects one event of layer-tagged 36-bit stubs into per-layer FIFOs, then
//   emits a gap-free frame to the stub router:
//     header {111, bx, 1FFFFFF} -> cumulative-count word -> stubs grouped by
//     layer (layer 0 first, arrival order within a layer) -> trailer {111, bx, 0}.
//
// Ports
//   clk         processing clock
//   reset       synchronous, active-high reset
//   stub_in     36-bit stub word
//   stub_layer  layer index of stub_in (0..NLAYERS-1 are valid)
//   stub_valid  stub_in/stub_layer valid this cycle
//   evt_end     last cycle of the event (a stub in the same cycle belongs to it)
//   bx_in       BX of the ending event, sampled with evt_end
//   in_ready    high only while collecting; input is ignored when low
//   stub_out    framed output word (registered)
//   out_valid   stub_out carries a frame word
//   frame_done  one-cycle pulse alongside the trailer word
//   drop_cnt    saturating count of dropped stubs since reset
// -----------------------------------------------------------------------------
module disk_stub_framer #(
   parameter int NLAYERS = 5,
   parameter int DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [35:0] stub_in,
   input  logic [2:0]  stub_layer,
   input  logic        stub_valid,
   input  logic        evt_end,
   input  logic [7:0]  bx_in,
   output logic        in_ready,
   output logic [35:0] stub_out,
   output logic        out_valid,
   output logic        frame_done,
   output logic [7:0]  drop_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   // The count word always has six fields; layers beyond NLAYERS keep a zero
   // count so their cumulative fields simply repeat the total.
   localparam int MAXL = 6;

   typedef enum logic [2:0] {
      COLLECT,
      HEAD,
      CNTS,
      STUBS,
      TRAIL
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q [MAXL];
   logic [5:0]     total_q;
   logic [7:0]     bx_q;
   logic [35:0]    mem [NLAYERS][DEPTH];
   logic [2:0]     rd_layer_q;
   logic [AW-1:0]  rd_idx_q;
   logic [5:0]     sent_q;

   logic           lay_ok;
   logic [2:0]     lay_idx;
   logic           lay_full;
   logic           accept;
   logic           drop;
   logic           evt_take;
   logic [35:0]    cnt_word;
   logic [2:0]     first_nz;
   logic [2:0]     next_nz;
   logic           last_stub;
   logic           layer_last;

   // ---------------------------------------------------------------------------
   // Input qualification
   // ---------------------------------------------------------------------------
   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no latch is inferred on any path.
   always_comb begin
      lay_ok   = int'(stub_layer) < NLAYERS;
      // Out-of-range layers are steered to index 0 so the count lookup never
      // reads past the array; such stubs are dropped anyway.
      lay_idx  = lay_ok ? stub_layer : 3'd0;
      lay_full = cnt_q[lay_idx] == CW'(DEPTH);
      accept   = in_ready && stub_valid && lay_ok && !lay_full && (total_q != 6'd63);
      drop     = stub_valid && !accept;
      evt_take = in_ready && evt_end;
   end

   // Cumulative counts C1..C6, C1 in the top field.
   always_comb begin
      logic [5:0] acc;
      acc      = '0;
      cnt_word = '0;
      for (int i = 0; i < MAXL; i++) begin
         acc = acc + 6'(cnt_q[i]);
         cnt_word[35-6*i -: 6] = acc;
      end
   end

   // Lowest non-empty layer overall, and lowest non-empty layer above the one
   // being read; the descending scan leaves the smallest match in place. This
   // lets the reader hop over empty layers without an idle cycle.
   always_comb begin
      first_nz = '0;
      next_nz  = '0;
      for (int l = MAXL - 1; l >= 0; l--) begin
         if (cnt_q[l] != '0) begin
            first_nz = 3'(l);
            if (l > int'(rd_layer_q)) next_nz = 3'(l);
         end
      end
   end

   always_comb begin
      last_stub  = sent_q == (total_q - 6'd1);
      layer_last = (CW'(rd_idx_q) + CW'(1)) == cnt_q[rd_layer_q];
   end

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (evt_take) state_d = HEAD;
         HEAD:    state_d = CNTS;
         CNTS:    state_d = (total_q == 6'd0) ? TRAIL : STUBS;
         STUBS:   if (last_stub) state_d = TRAIL;
         TRAIL:   state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) state_q <= COLLECT;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Stub buffers
   // ---------------------------------------------------------------------------
   // NOTE: the buffer array has no reset; clearing cnt_q empties it logically
   // and lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept) mem[lay_idx][cnt_q[lay_idx][AW-1:0]] <= stub_in;
   end

   // ---------------------------------------------------------------------------
   // Counters, handshake and registered output word
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAXL; i++) cnt_q[i] <= '0;
         total_q    <= '0;
         drop_cnt   <= '0;
         bx_q       <= '0;
         in_ready   <= 1'b1;
         rd_layer_q <= '0;
         rd_idx_q   <= '0;
         sent_q     <= '0;
         stub_out   <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q[lay_idx] <= cnt_q[lay_idx] + CW'(1);
            total_q        <= total_q + 6'd1;
         end
         if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

         // in_ready reopens on the cycle after the trailer word is on the bus.
         if (evt_take) begin
            bx_q     <= bx_in;
            in_ready <= 1'b0;
         end else if (frame_done) begin
            in_ready <= 1'b1;
         end

         stub_out   <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         unique case (state_q)
            HEAD: begin
               stub_out  <= {3'b111, bx_q, 25'h1FFFFFF};
               out_valid <= 1'b1;
            end
            CNTS: begin
               stub_out   <= cnt_word;
               out_valid  <= 1'b1;
               rd_layer_q <= first_nz;
               rd_idx_q   <= '0;
               sent_q     <= '0;
            end
            STUBS: begin
               stub_out  <= mem[rd_layer_q][rd_idx_q];
               out_valid <= 1'b1;
               sent_q    <= sent_q + 6'd1;
               if (layer_last) begin
                  rd_layer_q <= next_nz;
                  rd_idx_q   <= '0;
               end else begin
                  rd_idx_q <= rd_idx_q + AW'(1);
               end
            end
            TRAIL: begin
               stub_out   <= {3'b111, bx_q, 25'h0000000};
               out_valid  <= 1'b1;
               frame_done <= 1'b1;
               for (int i = 0; i < MAXL; i++) cnt_q[i] <= '0;
               total_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_disk_stub_framer.sv
// -----------------------------------------------------------------------------
// tb_disk_stub_framer
//   Directed stimulus with a scoreboard: a reference model of the per-layer
//   buffers builds each expected frame when evt_end is driven and queues its
//   words; a negedge monitor pops and compares every word the DUT emits.
// -----------------------------------------------------------------------------
module tb_disk_stub_framer;

   localparam int NL = 5;
   localparam int DP = 16;

   logic        clk;
   logic        reset;
   logic [35:0] stub_in;
   logic [2:0]  stub_layer;
   logic        stub_valid;
   logic        evt_end;
   logic [7:0]  bx_in;
   logic        in_ready;
   logic [35:0] stub_out;
   logic        out_valid;
   logic        frame_done;
   logic [7:0]  drop_cnt;

   disk_stub_framer #(.NLAYERS(NL), .DEPTH(DP)) dut (
      .clk        (clk),
      .reset      (reset),
      .stub_in    (stub_in),
      .stub_layer (stub_layer),
      .stub_valid (stub_valid),
      .evt_end    (evt_end),
      .bx_in      (bx_in),
      .in_ready   (in_ready),
      .stub_out   (stub_out),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [35:0] word;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          mid_frame = 1'b0;
   int          seq = 0;

   // Reference model state
   logic [35:0] m_buf [6][DP];
   int          m_cnt [6];
   int          m_total;
   int          m_drop;
   bit          m_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_total = 0;
   endtask

   task automatic build_frame(input logic [7:0] bx);
      exp_t        e;
      logic [35:0] w;
      int          acc;
      e.last = 1'b0;
      e.word = {3'b111, bx, 25'h1FFFFFF};
      sb.push_back(e);
      acc = 0;
      w   = '0;
      for (int i = 0; i < 6; i++) begin
         acc = acc + m_cnt[i];
         w[35-6*i -: 6] = 6'(acc);
      end
      e.word = w;
      sb.push_back(e);
      for (int l = 0; l < NL; l++)
         for (int k = 0; k < m_cnt[l]; k++) begin
            e.word = m_buf[l][k];
            sb.push_back(e);
         end
      e.word = {3'b111, bx, 25'h0000000};
      e.last = 1'b1;
      sb.push_back(e);
      model_clear();
      m_ready = 1'b0;
   endtask

   // Drive one cycle of input and update the model with what it should do.
   task automatic cycle(input bit v, input logic [35:0] d, input logic [2:0] l,
                        input bit e, input logic [7:0] b);
      stub_valid = v;
      stub_in    = d;
      stub_layer = l;
      evt_end    = e;
      bx_in      = b;
      if (v) begin
         if (!m_ready || int'(l) >= NL || m_cnt[l] == DP || m_total == 63) begin
            if (m_drop < 255) m_drop++;
         end else begin
            m_buf[l][m_cnt[l]] = d;
            m_cnt[l]++;
            m_total++;
         end
      end
      if (e && m_ready) build_frame(b);
      @(posedge clk);
      #1;
      stub_valid = 1'b0;
      evt_end    = 1'b0;
   endtask

   task automatic stub(input logic [2:0] l);
      seq++;
      cycle(1'b1, {4'hA, 1'b0, l, 28'(seq)}, l, 1'b0, 8'h00);
   endtask

   task automatic stub_evt(input logic [2:0] l, input logic [7:0] b);
      seq++;
      cycle(1'b1, {4'hA, 1'b0, l, 28'(seq)}, l, 1'b1, b);
   endtask

   task automatic evt(input logic [7:0] b);
      cycle(1'b0, 36'h0, 3'd0, 1'b1, b);
   endtask

   // Wait (bounded) for the queued frame to drain, then expect in_ready back.
   task automatic wait_frame(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " drained"}, 64'(sb.size()), 64'd0);
      check({tag, " in_ready after trailer"}, 64'(in_ready), 64'd1);
      m_ready = 1'b1;
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         mid_frame = 1'b0;
      end else if (mon_en) begin
         if (mid_frame) check("contiguous out_valid", 64'(out_valid), 64'd1);
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected word", 64'(out_valid), 64'd0);
               mid_frame = 1'b0;
            end else begin
               mon_e = sb.pop_front();
               check("frame word", 64'(stub_out), 64'(mon_e.word));
               check("frame_done", 64'(frame_done), 64'(mon_e.last));
               mid_frame = !mon_e.last;
            end
         end else begin
            check("idle stub_out", 64'(stub_out), 64'd0);
            check("idle frame_done", 64'(frame_done), 64'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      stub_in    = '0;
      stub_layer = '0;
      stub_valid = 1'b0;
      evt_end    = 1'b0;
      bx_in      = '0;
      model_clear();
      m_drop  = 0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Reset state
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset stub_out", 64'(stub_out), 64'd0);
      check("reset frame_done", 64'(frame_done), 64'd0);
      check("reset drop_cnt", 64'(drop_cnt), 64'd0);

      // T1: 3 stubs to L0, 2 to L2 (interleaved), bx=05
      stub(3'd0); stub(3'd2); stub(3'd0); stub(3'd2); stub(3'd0);
      evt(8'h05);
      check("T1 in_ready low in frame", 64'(in_ready), 64'd0);
      wait_frame("T1");

      // T2: empty event, bx=FF
      evt(8'hFF);
      wait_frame("T2");

      // T3: DEPTH+2 stubs to L1
      for (int i = 0; i < DP + 2; i++) stub(3'd1);
      check("T3 drop_cnt", 64'(drop_cnt), 64'(m_drop));
      evt(8'h33);
      wait_frame("T3");

      // T4: invalid layer, stubs and evt_end while busy
      stub(3'd7);
      check("T4 layer7 drop", 64'(drop_cnt), 64'(m_drop));
      stub(3'd0); stub(3'd4); stub(3'd3);
      evt(8'h44);
      stub(3'd0);
      stub_evt(3'd1, 8'h99);
      check("T4 busy drops", 64'(drop_cnt), 64'(m_drop));
      wait_frame("T4");

      // T5: stub and evt_end together; then reset during STUBS
      stub_evt(3'd3, 8'h55);
      wait_frame("T5a");
      stub(3'd0); stub(3'd0); stub(3'd4); stub(3'd4);
      evt(8'h66);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      model_clear();
      m_drop  = 0;
      m_ready = 1'b1;
      check("T5 out_valid after reset", 64'(out_valid), 64'd0);
      check("T5 in_ready after reset", 64'(in_ready), 64'd1);
      check("T5 drop_cnt after reset", 64'(drop_cnt), 64'd0);
      stub(3'd3); stub(3'd3);
      evt(8'h77);
      wait_frame("T5b");

      // T6: back-to-back events
      stub(3'd1);
      evt(8'h11);
      wait_frame("T6a");
      stub_evt(3'd4, 8'h22);
      wait_frame("T6b");

      // T7: total capped at 63 (64th stub dropped)
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < DP; i++) stub(3'(l));
      check("T7 cap drop_cnt", 64'(drop_cnt), 64'(m_drop));
      evt(8'hC3);
      wait_frame("T7");

      check("final drop_cnt", 64'(drop_cnt), 64'(m_drop));
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
